// File: rtl/group_serial_skip_subtractor.sv
// Multi-cycle subtractor D = A - B - Bin, one 4-bit group per clock, LSB group first.
// Each group uses a ripple of full-subtractor cells with a carry-skip style borrow bypass.
`timescale 1ns/1ps
module group_serial_skip_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] D,
    output logic             Bout
);

    localparam int GROUPS = WIDTH / 4;
    localparam int CNT_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam logic [CNT_W-1:0] LAST_GROUP = CNT_W'(GROUPS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [3:0] diff;
        logic       bout;
    } group_res_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             borrow_q, borrow_d;
    logic             bout_q, bout_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic [3:0]       grp_a;
    logic [3:0]       grp_b;
    group_res_t       grp_res;

    // Ripple of four full-subtractor cells; when every bit pair is equal the group
    // cannot generate or kill a borrow, so the incoming borrow is forwarded directly.
    function automatic group_res_t sub_group(input logic [3:0] ga,
                                             input logic [3:0] gb,
                                             input logic       bi);
        group_res_t res;
        logic [4:0] chain;
        logic       prop;
        chain    = '0;
        chain[0] = bi;
        res      = '0;
        for (int i = 0; i < 4; i++) begin
            res.diff[i]  = ga[i] ^ gb[i] ^ chain[i];
            chain[i + 1] = (~ga[i] & gb[i]) | (~(ga[i] ^ gb[i]) & chain[i]);
        end
        prop     = &(ga ~^ gb);
        res.bout = prop ? bi : chain[4];
        return res;
    endfunction

    always_comb begin
        grp_a   = a_q[{count_q, 2'b00} +: 4];
        grp_b   = b_q[{count_q, 2'b00} +: 4];
        grp_res = sub_group(grp_a, grp_b, borrow_q);
    end

    // NOTE: every _d gets its hold value first so no path through the case leaves a
    // variable unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        d_d         = d_q;
        borrow_d    = borrow_q;
        bout_d      = bout_q;
        count_d     = count_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                in_ready_d = 1'b1;
                if (in_valid && in_ready_q) begin
                    a_d        = A;
                    b_d        = B;
                    borrow_d   = Bin;
                    count_d    = '0;
                    in_ready_d = 1'b0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                d_d[{count_q, 2'b00} +: 4] = grp_res.diff;
                borrow_d = grp_res.bout;
                count_d  = count_q + 1'b1;
                if (count_q == LAST_GROUP) begin
                    bout_d      = grp_res.bout;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                // Result is frozen here until the consumer takes it.
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b0;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples the
    // pre-edge value of the others, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            d_q         <= '0;
            borrow_q    <= 1'b0;
            bout_q      <= 1'b0;
            count_q     <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            d_q         <= d_d;
            borrow_q    <= borrow_d;
            bout_q      <= bout_d;
            count_q     <= count_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign D         = d_q;
    assign Bout      = bout_q;

endmodule
